// File: rtl/onewire_reset_presence.sv
// onewire_reset_presence: 1-Wire master reset pulse generator with presence sampling and width measurement.
// Optional stuck-low bus detection is compiled in with `define ONEWIRE_SHORT_DETECT_EN.
module onewire_reset_presence #(
    parameter int CLK_PER_US  = 4,
    parameter int T_RSTL_US   = 480,
    parameter int T_SAMPLE_US = 70,
    parameter int T_RSTH_US   = 480,
    parameter int SYNC_STAGES = 2,
    parameter int LEN_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire              bus,
    input  logic             en_reset,
    output logic             busy,
    output logic             done,
    output logic             found_presence,
    output logic [LEN_W-1:0] presence_len,
    output logic             bus_short
);
    localparam int CNT_MAX = (T_RSTL_US > T_RSTH_US) ? T_RSTL_US : T_RSTH_US;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PRE_W   = $clog2(CLK_PER_US + 1);
    localparam int SET_W   = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {IDLE, RST_LOW, WAIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [PRE_W-1:0]       presc_q, presc_d;
    logic                   tick_q, tick_d;
    logic [CNT_W-1:0]       us_q, us_d;
    logic [SET_W-1:0]       settle_q, settle_d;
    logic                   drive_q, drive_d;
    logic                   found_q, found_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   short_q, short_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   bus_s;
    logic                   short_hit;

    assign bus   = drive_q ? 1'b0 : 1'bz;
    assign bus_s = sync_q[SYNC_STAGES-1];

`ifdef ONEWIRE_SHORT_DETECT_EN
    assign short_hit = ~bus_s;
`else
    assign short_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        presc_d  = (presc_q == PRE_W'(CLK_PER_US - 1)) ? '0 : presc_q + 1'b1;
        tick_d   = (presc_q == PRE_W'(CLK_PER_US - 1));
        us_d     = us_q;
        settle_d = settle_q;
        found_d  = found_q;
        len_d    = len_q;
        short_d  = short_q;
        case (state_q)
            IDLE: begin
                if (en_reset) begin
                    presc_d = '0;
                    tick_d  = 1'b0;
                    us_d    = '0;
                    found_d = 1'b0;
                    len_d   = '0;
                    short_d = short_hit;
                    state_d = short_hit ? DONE : RST_LOW;
                end
            end
            RST_LOW: begin
                if (tick_q) begin
                    us_d = us_q + 1'b1;
                    if (us_q == CNT_W'(T_RSTL_US - 1)) begin
                        us_d     = '0;
                        settle_d = '0;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                settle_d = (settle_q == SET_W'(SYNC_STAGES)) ? settle_q : settle_q + 1'b1;
                if (tick_q) begin
                    us_d = us_q + 1'b1;
                    // The synchroniser still shows the master's own low for its first cycles
                    if (!bus_s && settle_q == SET_W'(SYNC_STAGES))
                        len_d = (len_q == '1) ? len_q : len_q + 1'b1;
                    if (us_q == CNT_W'(T_SAMPLE_US - 1))
                        found_d = ~bus_s;
                    if (us_q == CNT_W'(T_RSTH_US - 1)) begin
                        short_d = short_hit;
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Registered drive starts one edge after accept and drops on the edge WAIT is entered
        drive_d = (state_q == RST_LOW) && (state_d == RST_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            us_q     <= '0;
            settle_q <= '0;
            drive_q  <= 1'b0;
            found_q  <= 1'b0;
            len_q    <= '0;
            short_q  <= 1'b0;
            sync_q   <= '1;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            us_q     <= us_d;
            settle_q <= settle_d;
            drive_q  <= drive_d;
            found_q  <= found_d;
            len_q    <= len_d;
            short_q  <= short_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus};
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign found_presence = found_q;
    assign presence_len   = len_q;
    assign bus_short      = short_q;
endmodule
